// File: rtl/hov_seq_pkg.sv
// Shared types and constants for the Hovalaag host-side sequencer.
package hov_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_I0,
    S_I1,
    S_I2,
    S_STAT,
    S_IN2,
    S_EXEC,
    S_PCRD,
    S_OUTL,
    S_OUTH,
    S_PUSH
  } hov_state_e;

  localparam logic [2:0] ADDR_OUTL = 3'd0;
  localparam logic [2:0] ADDR_OUTH = 3'd1;
  localparam logic [2:0] ADDR_STAT = 3'd2;
  localparam logic [2:0] ADDR_EXEC = 3'd3;
  localparam logic [2:0] ADDR_PC   = 3'd4;

  // Bit positions inside the 4-bit status word read at ADDR_STAT.
  localparam int unsigned ST_A1  = 0;
  localparam int unsigned ST_A2  = 1;
  localparam int unsigned ST_O1V = 2;
  localparam int unsigned ST_O2V = 3;

endpackage

// File: rtl/hov_sequencer_if.sv
// Bus bundle between the sequencer (master) and program memory, streams and wrapper (slave).
interface hov_sequencer_if #(
    parameter int PC_W = 8
);

  // Streams use valid/ready: a word moves on a rising edge where both are 1;
  // the source holds data stable while valid=1 and ready=0.
  logic [PC_W-1:0] prog_addr;
  logic            prog_rd;
  logic [31:0]     prog_data;
  logic [11:0]     in1_data;
  logic            in1_valid;
  logic            in1_ready;
  logic [11:0]     in2_data;
  logic            in2_valid;
  logic            in2_ready;
  logic [11:0]     out1_data;
  logic            out1_valid;
  logic            out1_ready;
  logic [11:0]     out2_data;
  logic            out2_valid;
  logic            out2_ready;
  logic [2:0]      hov_addr;
  logic [5:0]      hov_lo;
  logic [5:0]      hov_hi;
  logic [7:0]      hov_out;

  modport master (
    output prog_addr, prog_rd, in1_ready, in2_ready,
    output out1_data, out1_valid, out2_data, out2_valid,
    output hov_addr, hov_lo, hov_hi,
    input  prog_data, in1_data, in1_valid, in2_data, in2_valid,
    input  out1_ready, out2_ready, hov_out
  );

  modport slave (
    input  prog_addr, prog_rd, in1_ready, in2_ready,
    input  out1_data, out1_valid, out2_data, out2_valid,
    input  hov_addr, hov_lo, hov_hi,
    output prog_data, in1_data, in1_valid, in2_data, in2_valid,
    output out1_ready, out2_ready, hov_out
  );

endinterface

// File: rtl/hov_ddr_mux.sv
// Folds the two DDR halves onto the wrapper's 6-bit io_in: low half while clk=0
// (sampled at the rising edge), high half while clk=1 (sampled at the falling edge).
module hov_ddr_mux (
    input  logic       clk,
    input  logic [5:0] lo,
    input  logic [5:0] hi,
    output logic [5:0] io_in
);

  assign io_in = clk ? hi : lo;

endmodule

// File: rtl/hov_sequencer.sv
// Autonomous step sequencer for the Hovalaag CPU wrapper.
// Optional single-step input enabled by HOV_SEQ_SINGLE_STEP_EN.
module hov_sequencer
  import hov_seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
`ifdef HOV_SEQ_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              busy,
    output logic [PC_W-1:0]   pc,
    output logic [STEP_W-1:0] steps,
    output hov_state_e        state_dbg,
    hov_sequencer_if.master   bus
);

  hov_state_e        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        stat_q, stat_d;
  logic [11:0]       in2_val_q, in2_val_d;
  logic [11:0]       out_q, out_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [STEP_W-1:0] steps_q, steps_d;

  logic        start;
  logic        exec_go;
  logic [11:0] in2_pres;
  hov_state_e  bound_st;

`ifdef HOV_SEQ_SINGLE_STEP_EN
  assign start = run | step_req;
`else
  assign start = run;
`endif

  // A single-step returns to IDLE by itself because run=0 at the boundary.
  assign bound_st = run ? S_FETCH : S_IDLE;
  assign exec_go  = !(stat_q[ST_A1] && !bus.in1_valid);
  assign in2_pres = bus.in2_valid ? bus.in2_data : 12'h000;

  assign busy          = (state_q != S_IDLE);
  assign pc            = pc_q;
  assign steps         = steps_q;
  assign state_dbg     = state_q;
  assign bus.prog_addr = pc_q;
  assign bus.out1_data = out_q;
  assign bus.out2_data = out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      stat_q    <= '0;
      in2_val_q <= '0;
      out_q     <= '0;
      pc_q      <= '0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      stat_q    <= stat_d;
      in2_val_q <= in2_val_d;
      out_q     <= out_d;
      pc_q      <= pc_d;
      steps_q   <= steps_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    stat_d         = stat_q;
    in2_val_d      = in2_val_q;
    out_d          = out_q;
    pc_d           = pc_q;
    steps_d        = steps_q;
    bus.prog_rd    = 1'b0;
    bus.in1_ready  = 1'b0;
    bus.in2_ready  = 1'b0;
    bus.out1_valid = 1'b0;
    bus.out2_valid = 1'b0;
    // Idle default re-presents the top instruction slice, so it never disturbs the wrapper.
    bus.hov_addr   = ADDR_STAT;
    bus.hov_lo     = ir_q[29:24];
    bus.hov_hi     = {4'b0000, ir_q[31:30]};

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.prog_rd = 1'b1;
        state_d     = S_FWAIT;
      end
      S_FWAIT: begin
        ir_d    = bus.prog_data;
        state_d = S_I0;
      end
      S_I0: begin
        bus.hov_addr = ADDR_OUTL;
        bus.hov_lo   = ir_q[5:0];
        bus.hov_hi   = ir_q[11:6];
        state_d      = S_I1;
      end
      S_I1: begin
        bus.hov_addr = ADDR_OUTH;
        bus.hov_lo   = ir_q[17:12];
        bus.hov_hi   = ir_q[23:18];
        state_d      = S_I2;
      end
      S_I2: begin
        state_d = S_STAT;
      end
      S_STAT: begin
        stat_d  = bus.hov_out[3:0];
        state_d = S_IN2;
      end
      S_IN2: begin
        bus.hov_addr = ADDR_PC;
        bus.hov_lo   = in2_pres[5:0];
        bus.hov_hi   = in2_pres[11:6];
        in2_val_d    = in2_pres;
        if (!(stat_q[ST_A2] && !bus.in2_valid)) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_go) begin
          bus.hov_addr  = ADDR_EXEC;
          bus.hov_lo    = bus.in1_data[5:0];
          bus.hov_hi    = bus.in1_data[11:6];
          bus.in1_ready = stat_q[ST_A1];
          bus.in2_ready = stat_q[ST_A2];
          steps_d       = steps_q + 1'b1;
          state_d       = S_PCRD;
        end else begin
          bus.hov_addr = ADDR_PC;
          bus.hov_lo   = in2_val_q[5:0];
          bus.hov_hi   = in2_val_q[11:6];
        end
      end
      S_PCRD: begin
        bus.hov_addr = ADDR_PC;
        bus.hov_lo   = in2_val_q[5:0];
        bus.hov_hi   = in2_val_q[11:6];
        pc_d         = PC_W'(bus.hov_out);
        state_d      = (stat_q[ST_O1V] || stat_q[ST_O2V]) ? S_OUTL : bound_st;
      end
      S_OUTL: begin
        bus.hov_addr = ADDR_OUTL;
        bus.hov_lo   = ir_q[5:0];
        bus.hov_hi   = ir_q[11:6];
        out_d[7:0]   = bus.hov_out;
        state_d      = S_OUTH;
      end
      S_OUTH: begin
        bus.hov_addr = ADDR_OUTH;
        bus.hov_lo   = ir_q[17:12];
        bus.hov_hi   = ir_q[23:18];
        out_d[11:8]  = bus.hov_out[3:0];
        state_d      = S_PUSH;
      end
      S_PUSH: begin
        // OUT1 wins when the CPU flags both outputs.
        if (stat_q[ST_O1V]) begin
          bus.out1_valid = 1'b1;
          if (bus.out1_ready) state_d = bound_st;
        end else begin
          bus.out2_valid = 1'b1;
          if (bus.out2_ready) state_d = bound_st;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
